// File: rtl/exp_align_pipe.sv
// exp_align_pipe: two-stage exponent compare and mantissa alignment for the
// FP add/sub datapath. Stage 1 orders the operands by exponent and forms the
// exponent difference; stage 2 right-shifts the smaller mantissa (extended by
// guard and round bits) and collects the shifted-out bits into sticky.
//
// Handshake (both sides, strict valid/ready): a transfer happens on a rising
// clock edge where valid and ready are both high. A producer holding valid
// keeps its data stable until the transfer; ready may depend combinationally
// on downstream ready (in_ready follows out_ready through the stage-advance
// chain; there is no skid buffer).
module exp_align_pipe #(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] exp_a,
  input  logic [EW-1:0] exp_b,
  input  logic [MW:0]   man_a,
  input  logic [MW:0]   man_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] exp_big,
  output logic [EW-1:0] diff,
  output logic          a_ge_b,
  output logic [MW:0]   man_big,
  output logic [MW+2:0] man_small_aln,
  output logic          sticky
);

  localparam int SW = MW + 3;                 // extended mantissa width
  localparam logic [SW-1:0] ONES = '1;

  // stage 1 registers
  logic          s1_valid;
  logic [EW-1:0] s1_exp_big;
  logic [EW-1:0] s1_diff;
  logic          s1_a_ge_b;
  logic [MW:0]   s1_man_big;
  logic [MW:0]   s1_man_small;

  // stage advance chain; the output register is stage 2
  logic s2_adv;
  logic s1_adv;

  // stage advance and upstream ready
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  // stage 1 combinational: one wide subtract gives both order and magnitude
  logic [EW:0]   sub;
  logic          borrow;
  logic [EW-1:0] diff_d;
  always_comb begin
    sub    = {1'b0, exp_a} - {1'b0, exp_b};
    borrow = sub[EW];
    diff_d = borrow ? (~sub[EW-1:0] + EW'(1)) : sub[EW-1:0];
  end

  // stage 1 register: capture ordered operands whenever the stage advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_exp_big   <= '0;
      s1_diff      <= '0;
      s1_a_ge_b    <= 1'b0;
      s1_man_big   <= '0;
      s1_man_small <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_diff      <= diff_d;
        s1_a_ge_b    <= !borrow;
        s1_exp_big   <= borrow ? exp_b : exp_a;
        s1_man_big   <= borrow ? man_b : man_a;
        s1_man_small <= borrow ? man_a : man_b;
      end
    end
  end

  // stage 2 combinational: alignment shift with saturation and sticky
  logic [SW-1:0] ext;
  logic [SW-1:0] mask;
  logic [SW-1:0] aln_d;
  logic          sat;
  logic          sticky_d;
  always_comb begin
    ext      = {s1_man_small, 2'b00};
    mask     = '0;
    aln_d    = '0;
    sticky_d = 1'b0;
    sat      = (32'(s1_diff) >= 32'(SW));
    if (sat) begin
      // everything is shifted out; any set mantissa bit lands in sticky
      sticky_d = |s1_man_small;
    end else begin
      aln_d    = ext >> s1_diff;
      mask     = ~(ONES << s1_diff);
      sticky_d = |(ext & mask);
    end
  end

  // stage 2 register: these are the module outputs and hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      exp_big       <= '0;
      diff          <= '0;
      a_ge_b        <= 1'b0;
      man_big       <= '0;
      man_small_aln <= '0;
      sticky        <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        exp_big       <= s1_exp_big;
        diff          <= s1_diff;
        a_ge_b        <= s1_a_ge_b;
        man_big       <= s1_man_big;
        man_small_aln <= aln_d;
        sticky        <= sticky_d;
      end
    end
  end

endmodule

// File: tb/tb_exp_align_pipe.sv
// tb_exp_align_pipe: directed and randomized checks of exp_align_pipe against
// an arithmetic reference model, with a scoreboard queue of expected results.
module tb_exp_align_pipe;

  localparam int EW  = 5;
  localparam int MW  = 10;
  localparam int MBW = MW + 1;
  localparam int ALW = MW + 3;
  localparam int RW  = EW + EW + 1 + MBW + ALW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] exp_a = '0;
  logic [EW-1:0] exp_b = '0;
  logic [MW:0]   man_a = '0;
  logic [MW:0]   man_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [EW-1:0] exp_big;
  logic [EW-1:0] diff;
  logic          a_ge_b;
  logic [MW:0]   man_big;
  logic [MW+2:0] man_small_aln;
  logic          sticky;

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got;

  // clock/reset block
  always #5 clk = ~clk;

  exp_align_pipe #(.EW(EW), .MW(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_big(exp_big), .diff(diff), .a_ge_b(a_ge_b), .man_big(man_big),
    .man_small_aln(man_small_aln), .sticky(sticky)
  );

  always_comb got = {exp_big, diff, a_ge_b, man_big, man_small_aln, sticky};

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // reference model: plain integer arithmetic on the alignment rules
  function automatic logic [RW-1:0] model(input int ea, input int eb, input int ma, input int mb);
    int big, d, mbig, ms, ext, aln, st, ge;
    ge   = (ea >= eb) ? 1 : 0;
    big  = ge ? ea : eb;
    d    = ge ? ea - eb : eb - ea;
    mbig = ge ? ma : mb;
    ms   = ge ? mb : ma;
    ext  = ms * 4;
    if (d >= ALW) begin
      aln = 0;
      st  = (ms != 0) ? 1 : 0;
    end else begin
      aln = ext / (2 ** d);
      st  = ((ext % (2 ** d)) != 0) ? 1 : 0;
    end
    return {EW'(big), EW'(d), 1'(ge), MBW'(mbig), ALW'(aln), 1'(st)};
  endfunction

  function automatic logic [RW-1:0] pack(input int eb, input int d, input int ge,
                                         input int mb, input int al, input int st);
    return {EW'(eb), EW'(d), 1'(ge), MBW'(mb), ALW'(al), 1'(st)};
  endfunction

  // scoreboard: sample away from the active edge, transfers occur at the next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(exp_a, exp_b, man_a, man_b));
      if (out_valid && out_ready) begin
        check("out_has_expect", RW'(exp_q.size() != 0), RW'(1));
        if (exp_q.size() != 0) check("sb_result", got, exp_q.pop_front());
      end
    end
  end

  // driver: present one pair and wait (bounded) for it to be accepted
  task automatic send(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                      input logic [MW:0] ma, input logic [MW:0] mb);
    logic acc;
    int t;
    t = 0;
    acc = 1'b0;
    exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
    in_valid = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) check("send_timeout", RW'(acc), RW'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", RW'(exp_q.size()), RW'(0));
  endtask

  // directed single pair on an empty pipe: checks latency and spec values
  task automatic directed(input string tag, input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                          input logic [MW:0] ma, input logic [MW:0] mb, input logic [RW-1:0] exp);
    out_ready = 1'b1;
    exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid_c1"}, RW'(out_valid), RW'(0));
    @(posedge clk); #1;
    check({tag, "_valid_c2"}, RW'(out_valid), RW'(1));
    check({tag, "_data"}, got, exp);
    @(posedge clk); #1;
  endtask

  logic [RW-1:0] snap;
  logic          done;

  initial begin
    // reset state
    #1;
    check("rst_out_valid", RW'(out_valid), RW'(0));
    check("rst_data", got, RW'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", RW'(in_ready), RW'(1));

    // directed vectors
    directed("t1", 5'd18, 5'd15, 11'h400, 11'h600, pack(18, 3, 1, 'h400, 'h0300, 0));
    directed("t2", 5'd10, 5'd13, 11'h401, 11'h7FF, pack(13, 3, 0, 'h7FF, 'h0200, 1));
    directed("t3a", 5'd25, 5'd5, 11'h7FF, 11'h400, pack(25, 20, 1, 'h7FF, 0, 1));
    directed("t3b", 5'd25, 5'd12, 11'h7FF, 11'h400, pack(25, 13, 1, 'h7FF, 0, 1));
    directed("t4", 5'd7, 5'd7, 11'h500, 11'h6AA, pack(7, 0, 1, 'h500, 'h1AA8, 0));
    directed("d12", 5'd0, 5'd12, 11'h7FF, 11'h401, pack(12, 12, 0, 'h401, 'h1, 1));
    drain();

    // backpressure: fill both stages, hold outputs, then release
    out_ready = 1'b0;
    send(5'd20, 5'd18, 11'h5A5, 11'h4F3);
    send(5'd3, 5'd9, 11'h7C1, 11'h6EE);
    check("bp_in_ready_full", RW'(in_ready), RW'(0));
    check("bp_out_valid", RW'(out_valid), RW'(1));
    snap = got;
    exp_a = 5'd30; exp_b = 5'd31; man_a = 11'h432; man_b = 11'h765;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ready", RW'(in_ready), RW'(0));
      check("bp_hold_data", got, snap);
    end
    out_ready = 1'b1;
    send(5'd30, 5'd31, 11'h432, 11'h765);
    send(5'd11, 5'd11, 11'h7FF, 11'h400);
    drain();

    // asynchronous reset with two pairs in flight
    out_ready = 1'b1;
    send(5'd17, 5'd2, 11'h6B3, 11'h5D1);
    send(5'd4, 5'd6, 11'h412, 11'h7AB);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", RW'(out_valid), RW'(0));
    check("arst_data", got, RW'(0));
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("arst_no_stale", RW'(out_valid), RW'(0));
    end

    // randomized stream with random backpressure
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [EW-1:0] ea, eb;
          ea = EW'($urandom_range(0, 31));
          eb = ($urandom_range(0, 5) == 0) ? ea : EW'($urandom_range(0, 31));
          send(ea, eb, MBW'($urandom_range(0, 2047)), MBW'($urandom_range(0, 2047)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
